// File: rtl/rv16_ex_stage.sv
// rv16_ex_stage: execute-stage pipeline wrapper around the RV16 ALU.
//
// Decoded instructions are captured into an ID/EX register (stage 1).
// From there the stage drives the external ALU's operand and opcode ports.
// Operands are forwarded from the EX/MEM entry when it writes a source
// register. Conditional branches are resolved from the ALU compare result.
// ALU result, flags, rd, the branch decision and the branch target are
// registered into an EX/MEM register (stage 2). Both sides use valid/ready.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_flush                  squash the ID/EX instruction
//   i_valid / o_ready        upstream handshake
//   i_pc .. i_wb_en          decoded instruction fields
//   o_alu_a/o_alu_b/o_alu_op ALU drive (combinational from ID/EX)
//   i_alu_result/zero/ovf/c  ALU response
//   o_valid / i_ready        downstream handshake
//   o_result .. o_branch_target  registered EX/MEM contents
module rv16_ex_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_use_imm,
  input  logic [3:0]      i_alu_op,
  input  logic            i_is_branch,
  input  logic [2:0]      i_br_cond,
  input  logic [RW-1:0]   i_rs1_addr,
  input  logic [RW-1:0]   i_rs2_addr,
  input  logic [RW-1:0]   i_rd_addr,
  input  logic            i_wb_en,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_op,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_alu_zero,
  input  logic            i_alu_overflow,
  input  logic            i_alu_carry,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [RW-1:0]   o_rd_addr,
  output logic            o_wb_en,
  output logic            o_overflow,
  output logic            o_carry,
  output logic            o_branch_taken,
  output logic [XLEN-1:0] o_branch_target
);

  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;

  // ID/EX register
  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_pc_q, s1_rs1_val_q, s1_rs2_val_q, s1_imm_q;
  logic            s1_use_imm_q, s1_is_branch_q, s1_wb_en_q;
  logic [3:0]      s1_alu_op_q;
  logic [2:0]      s1_br_cond_q;
  logic [RW-1:0]   s1_rs1_addr_q, s1_rs2_addr_q, s1_rd_addr_q;

  // EX/MEM register
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_result_q, s2_target_q;
  logic [RW-1:0]   s2_rd_addr_q;
  logic            s2_wb_en_q, s2_overflow_q, s2_carry_q, s2_taken_q;

  logic            s2_free, s1_adv, accept;
  logic            fwd_a, fwd_b;
  logic [XLEN-1:0] rs1_op, rs2_op, target;
  logic            taken;

  assign s2_free = !s2_valid_q || i_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign o_ready = !i_flush && (!s1_valid_q || s1_adv);
  assign accept  = i_valid && o_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)                 s1_valid_d = 1'b1;
    else if (i_flush || s1_adv) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s1_adv)                      s2_valid_d = 1'b1;
    else if (s2_valid_q && i_ready)  s2_valid_d = 1'b0;
  end

  // ---- Stage 1 (ID/EX): forwarding, ALU drive, branch resolution ----
  // Only the EX/MEM entry can forward; it holds the immediately older
  // instruction, whose result is not yet in the register file.
  assign fwd_a  = s2_valid_q && s2_wb_en_q && (s2_rd_addr_q != '0) &&
                  (s2_rd_addr_q == s1_rs1_addr_q);
  assign fwd_b  = s2_valid_q && s2_wb_en_q && (s2_rd_addr_q != '0) &&
                  (s2_rd_addr_q == s1_rs2_addr_q);
  assign rs1_op = fwd_a ? s2_result_q : s1_rs1_val_q;
  assign rs2_op = fwd_b ? s2_result_q : s1_rs2_val_q;

  assign o_alu_a = rs1_op;
  assign target  = s1_pc_q + s1_imm_q;

  // Branches always compare rs1 against rs2; the compare opcode is chosen
  // from the condition, and the decision reads zero or result bit 0.
  always_comb begin
    o_alu_b  = s1_use_imm_q ? s1_imm_q : rs2_op;
    o_alu_op = s1_alu_op_q;
    taken    = 1'b0;
    if (s1_is_branch_q) begin
      o_alu_b = rs2_op;
      case (s1_br_cond_q)
        3'b000: begin o_alu_op = OP_SUB;  taken = i_alu_zero;        end
        3'b001: begin o_alu_op = OP_SUB;  taken = !i_alu_zero;       end
        3'b100: begin o_alu_op = OP_SLT;  taken = i_alu_result[0];   end
        3'b101: begin o_alu_op = OP_SLT;  taken = !i_alu_result[0];  end
        3'b110: begin o_alu_op = OP_SLTU; taken = i_alu_result[0];   end
        3'b111: begin o_alu_op = OP_SLTU; taken = !i_alu_result[0];  end
        default: begin o_alu_op = OP_SUB; taken = 1'b0;              end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_pc_q        <= '0;
      s1_rs1_val_q   <= '0;
      s1_rs2_val_q   <= '0;
      s1_imm_q       <= '0;
      s1_use_imm_q   <= 1'b0;
      s1_alu_op_q    <= '0;
      s1_is_branch_q <= 1'b0;
      s1_br_cond_q   <= '0;
      s1_rs1_addr_q  <= '0;
      s1_rs2_addr_q  <= '0;
      s1_rd_addr_q   <= '0;
      s1_wb_en_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_pc_q        <= i_pc;
        s1_rs1_val_q   <= i_rs1_val;
        s1_rs2_val_q   <= i_rs2_val;
        s1_imm_q       <= i_imm;
        s1_use_imm_q   <= i_use_imm;
        s1_alu_op_q    <= i_alu_op;
        s1_is_branch_q <= i_is_branch;
        s1_br_cond_q   <= i_br_cond;
        s1_rs1_addr_q  <= i_rs1_addr;
        s1_rs2_addr_q  <= i_rs2_addr;
        s1_rd_addr_q   <= i_rd_addr;
        s1_wb_en_q     <= i_wb_en;
      end
    end
  end

  // ---- Stage 2 (EX/MEM): registered result, held while stalled ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_target_q   <= '0;
      s2_rd_addr_q  <= '0;
      s2_wb_en_q    <= 1'b0;
      s2_overflow_q <= 1'b0;
      s2_carry_q    <= 1'b0;
      s2_taken_q    <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        s2_result_q   <= i_alu_result;
        s2_target_q   <= target;
        s2_rd_addr_q  <= s1_rd_addr_q;
        // Writes to x0 are dropped here so later forwarding never sees them.
        s2_wb_en_q    <= s1_wb_en_q && (s1_rd_addr_q != '0);
        s2_overflow_q <= i_alu_overflow;
        s2_carry_q    <= i_alu_carry;
        s2_taken_q    <= taken;
      end
    end
  end

  assign o_valid         = s2_valid_q;
  assign o_result        = s2_result_q;
  assign o_rd_addr       = s2_rd_addr_q;
  assign o_wb_en         = s2_wb_en_q;
  assign o_overflow      = s2_overflow_q;
  assign o_carry         = s2_carry_q;
  assign o_branch_taken  = s2_taken_q;
  assign o_branch_target = s2_target_q;

endmodule

// File: tb/tb_rv16_ex_stage.sv
module tb_rv16_ex_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, o_ready;
  logic [31:0] i_pc, i_rs1_val, i_rs2_val, i_imm;
  logic        i_use_imm;
  logic [3:0]  i_alu_op;
  logic        i_is_branch;
  logic [2:0]  i_br_cond;
  logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic        i_wb_en;
  logic [31:0] o_alu_a, o_alu_b;
  logic [3:0]  o_alu_op;
  logic [31:0] i_alu_result;
  logic        i_alu_zero, i_alu_overflow, i_alu_carry;
  logic        o_valid, i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;
  logic        o_wb_en, o_overflow, o_carry, o_branch_taken;
  logic [31:0] o_branch_target;

  always #5 i_clk = ~i_clk;

  rv16_ex_stage #(.XLEN(32), .RW(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val), .i_imm(i_imm),
    .i_use_imm(i_use_imm), .i_alu_op(i_alu_op), .i_is_branch(i_is_branch),
    .i_br_cond(i_br_cond), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rd_addr(i_rd_addr), .i_wb_en(i_wb_en),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero),
    .i_alu_overflow(i_alu_overflow), .i_alu_carry(i_alu_carry),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_rd_addr(o_rd_addr), .o_wb_en(o_wb_en),
    .o_overflow(o_overflow), .o_carry(o_carry),
    .o_branch_taken(o_branch_taken), .o_branch_target(o_branch_target)
  );

  // Reference ALU: ADD, SUB (carry = borrow), SLT, SLTU.
  logic [32:0] sum;
  always_comb begin
    i_alu_result   = '0;
    i_alu_carry    = 1'b0;
    i_alu_overflow = 1'b0;
    sum            = '0;
    case (o_alu_op)
      4'b0000: begin
        sum            = {1'b0, o_alu_a} + {1'b0, o_alu_b};
        i_alu_result   = sum[31:0];
        i_alu_carry    = sum[32];
        i_alu_overflow = (o_alu_a[31] == o_alu_b[31]) && (sum[31] != o_alu_a[31]);
      end
      4'b1000: begin
        i_alu_result   = o_alu_a - o_alu_b;
        i_alu_carry    = o_alu_a < o_alu_b;
        i_alu_overflow = (o_alu_a[31] != o_alu_b[31]) && (i_alu_result[31] != o_alu_a[31]);
      end
      4'b0010: i_alu_result = {31'd0, $signed(o_alu_a) < $signed(o_alu_b)};
      4'b0011: i_alu_result = {31'd0, o_alu_a < o_alu_b};
      default: i_alu_result = '0;
    endcase
  end
  assign i_alu_zero = (i_alu_result == 32'd0);

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic        use_imm;
    logic [3:0]  op;
    logic        is_br;
    logic [2:0]  cond;
    logic [4:0]  rs1a, rs2a, rda;
    logic        wb;
    logic [31:0] e_res;
    logic        e_wb, e_ovf, e_car, e_tk;
    logic [31:0] e_tgt;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb, ovf, car, tk;
    logic [31:0] tgt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[15];

  function automatic vec_t mk(logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] imm, logic use_imm, logic [3:0] op,
                              logic is_br, logic [2:0] cond, logic [4:0] rs1a,
                              logic [4:0] rs2a, logic [4:0] rda, logic wb,
                              logic [31:0] e_res, logic e_wb, logic e_ovf,
                              logic e_car, logic e_tk, logic [31:0] e_tgt);
    vec_t v;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.use_imm = use_imm;
    v.op = op; v.is_br = is_br; v.cond = cond; v.rs1a = rs1a; v.rs2a = rs2a;
    v.rda = rda; v.wb = wb; v.e_res = e_res; v.e_wb = e_wb; v.e_ovf = e_ovf;
    v.e_car = e_car; v.e_tk = e_tk; v.e_tgt = e_tgt;
    return v;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Scoreboard monitor: the head entry must be presented whenever o_valid
  // is high (also while stalled); it is retired on a completed handshake.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual res=%h rd=%0d required=no output",
                 o_result, o_rd_addr);
      end else begin
        if ({o_result, o_rd_addr, o_wb_en, o_overflow, o_carry, o_branch_taken, o_branch_target}
            !== {sbq[0].res, sbq[0].rd, sbq[0].wb, sbq[0].ovf, sbq[0].car, sbq[0].tk, sbq[0].tgt}) begin
          failures++;
          $display("FAIL sb_out actual res=%h rd=%0d wb=%b ovf=%b c=%b tk=%b tgt=%h required res=%h rd=%0d wb=%b ovf=%b c=%b tk=%b tgt=%h",
                   o_result, o_rd_addr, o_wb_en, o_overflow, o_carry, o_branch_taken, o_branch_target,
                   sbq[0].res, sbq[0].rd, sbq[0].wb, sbq[0].ovf, sbq[0].car, sbq[0].tk, sbq[0].tgt);
        end
        if (i_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic drive(input vec_t v);
    i_pc = v.pc; i_rs1_val = v.rs1; i_rs2_val = v.rs2; i_imm = v.imm;
    i_use_imm = v.use_imm; i_alu_op = v.op; i_is_branch = v.is_br;
    i_br_cond = v.cond; i_rs1_addr = v.rs1a; i_rs2_addr = v.rs2a;
    i_rd_addr = v.rda; i_wb_en = v.wb;
  endtask

  // Offer one instruction; returns at accept edge + 1.
  task automatic send(input vec_t v, input bit push);
    exp_t e;
    bit   ok = 1'b0;
    drive(v);
    i_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (o_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=o_ready low required=accept");
    end else begin
      if (push) begin
        e.res = v.e_res; e.rd = v.rda; e.wb = v.e_wb; e.ovf = v.e_ovf;
        e.car = v.e_car; e.tk = v.e_tk; e.tgt = v.e_tgt;
        sbq.push_back(e);
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge i_clk);
      if (sbq.size() == 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sbq.size());
    end
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  initial begin
    //                pc            rs1           rs2  imm        ui op  br cond    a1  a2  rd wb  e_res         wb ov c  tk tgt
    tbl[0]  = mk(32'h0,   32'd5,        32'd7, 32'd0,   0, 4'h0, 0, 3'b000, 1,  2,  5,  1, 32'd12,        1, 0, 0, 0, 32'h0);
    tbl[1]  = mk(32'h4,   32'd0,        32'd0, 32'd10,  1, 4'h0, 0, 3'b000, 0,  0,  3,  1, 32'd10,        1, 0, 0, 0, 32'd14);
    tbl[2]  = mk(32'h8,   32'd0,        32'd0, 32'd0,   0, 4'h0, 0, 3'b000, 3,  3,  4,  1, 32'd20,        1, 0, 0, 0, 32'd8);
    tbl[3]  = mk(32'hC,   32'd0,        32'd0, 32'd10,  1, 4'h0, 0, 3'b000, 0,  0,  0,  1, 32'd10,        0, 0, 0, 0, 32'd22);
    tbl[4]  = mk(32'h10,  32'd0,        32'd0, 32'd0,   0, 4'h0, 0, 3'b000, 0,  0,  4,  1, 32'd0,         1, 0, 0, 0, 32'h10);
    tbl[5]  = mk(32'h0,   32'h7FFFFFFF, 32'd1, 32'd0,   0, 4'h0, 0, 3'b000, 6,  7,  8,  1, 32'h80000000,  1, 1, 0, 0, 32'h0);
    tbl[6]  = mk(32'h0,   32'hFFFFFFFF, 32'd1, 32'd0,   0, 4'h0, 0, 3'b000, 10, 11, 9,  1, 32'd0,         1, 0, 1, 0, 32'h0);
    tbl[7]  = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20,  1, 4'h0, 1, 3'b100, 12, 13, 0,  0, 32'd1,         0, 0, 0, 1, 32'h120);
    tbl[8]  = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20,  0, 4'h0, 1, 3'b110, 12, 13, 0,  0, 32'd0,         0, 0, 0, 0, 32'h120);
    tbl[9]  = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20,  0, 4'h0, 1, 3'b111, 12, 13, 0,  0, 32'd0,         0, 0, 0, 1, 32'h120);
    tbl[10] = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20,  0, 4'h0, 1, 3'b101, 12, 13, 0,  0, 32'd1,         0, 0, 0, 0, 32'h120);
    tbl[11] = mk(32'h100, 32'd3,        32'd3, 32'h20,  0, 4'h0, 1, 3'b000, 12, 13, 0,  0, 32'd0,         0, 0, 0, 1, 32'h120);
    tbl[12] = mk(32'h100, 32'd3,        32'd3, 32'h20,  0, 4'h0, 1, 3'b001, 12, 13, 0,  0, 32'd0,         0, 0, 0, 0, 32'h120);
    tbl[13] = mk(32'h100, 32'd5,        32'd3, 32'h20,  0, 4'h0, 1, 3'b010, 12, 13, 0,  0, 32'd2,         0, 0, 0, 0, 32'h120);
    tbl[14] = mk(32'h0,   32'd3,        32'd5, 32'd0,   0, 4'h8, 0, 3'b000, 15, 16, 14, 1, 32'hFFFFFFFE,  1, 0, 1, 0, 32'h0);

    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    #12;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_result", o_result, 32'd0);
    chk("rst_o_target", o_branch_target, 32'd0);
    chk("rst_o_wb_en", 32'(o_wb_en), 32'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_o_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;

    // Latency: o_valid appears after the edge following acceptance
    send(tbl[0], 1'b1);
    @(negedge i_clk);
    chk("lat_not_yet", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    chk("lat_valid", 32'(o_valid), 32'd1);
    drain();

    // Table vectors, back to back
    for (int i = 0; i < 15; i++) send(tbl[i], 1'b1);
    drain();

    // Backpressure: X, Y accepted, Z held off; Y and Z forward from elders
    i_ready = 1'b0;
    send(mk(0, 1, 2, 0, 0, 4'h0, 0, 0, 20, 21, 22, 1, 3, 1, 0, 0, 0, 0), 1'b1);
    send(mk(4, 0, 10, 0, 0, 4'h0, 0, 0, 22, 0, 23, 1, 13, 1, 0, 0, 0, 4), 1'b1);
    drive(mk(8, 0, 1, 0, 0, 4'h0, 0, 0, 23, 0, 24, 1, 14, 1, 0, 0, 0, 8));
    i_valid = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      chk("bp_o_ready_low", 32'(o_ready), 32'd0);
      chk("bp_o_valid_held", 32'(o_valid), 32'd1);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    send(mk(8, 0, 1, 0, 0, 4'h0, 0, 0, 23, 0, 24, 1, 14, 1, 0, 0, 0, 8), 1'b1);
    drain();

    // Flush of ID/EX while EX/MEM is stalled
    i_ready = 1'b0;
    send(mk(0, 2, 4, 0, 0, 4'h0, 0, 0, 1, 2, 25, 1, 6, 1, 0, 0, 0, 0), 1'b1);
    send(mk(0, 9, 9, 0, 0, 4'h0, 0, 0, 1, 2, 26, 1, 18, 1, 0, 0, 0, 0), 1'b0);
    i_flush = 1'b1;
    @(negedge i_clk);
    chk("flush_blocks_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_s1_cleared", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    drain();
    send(mk(0, 0, 5, 0, 0, 4'h0, 0, 0, 26, 2, 27, 1, 5, 1, 0, 0, 0, 0), 1'b1);
    drain();

    // Asynchronous reset mid-stream
    i_ready = 1'b0;
    send(mk(0, 40, 2, 0, 0, 4'h0, 0, 0, 1, 2, 28, 1, 42, 1, 0, 0, 0, 0), 1'b1);
    send(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 1, 2, 29, 1, 2, 1, 0, 0, 0, 0), 1'b1);
    #2;
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_result", o_result, 32'd0);
    chk("async_rst_ready", 32'(o_ready), 32'd1);
    sbq.delete();
    @(negedge i_clk); i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    send(tbl[0], 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
